// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and frame boundaries from a VGA-style timing stream.
// Coordinates and frame markers are qualified only after one verified clean frame.
module vga_sync_decoder #(
    parameter int unsigned HMAX = 640,
    parameter int unsigned VMAX = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        video_on,
    input  logic        vsync_n,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        frame_end,
    output logic        locked,
    output logic        sync_err,
    output logic [7:0]  err_count
);

    localparam int unsigned CW = 11;
    localparam int unsigned EW = 8;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ARM    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            von_d;
    logic            vs_d;
    logic [CW-1:0]   hc;
    logic [CW-1:0]   vc;
    logic [CW-1:0]   lines;
    logic            line_end;
    logic            vs_edge;
    logic            active;
    logic            err;

    assign line_end = tick & von_d & ~video_on;
    assign vs_edge  = tick & vs_d & ~vsync_n;
    assign active   = tick & video_on;
    assign lines    = vc + CW'(line_end);

    // Timing checks apply only once a frame boundary has been seen.
    always_comb begin
        err = 1'b0;
        if (state != HUNT) begin
            if (active && (hc == CW'(HMAX)))
                err = 1'b1;
            if (line_end && (hc != CW'(HMAX)))
                err = 1'b1;
            if (line_end && (vc == CW'(VMAX)))
                err = 1'b1;
            if (vs_edge && (lines != CW'(VMAX)))
                err = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= HUNT;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            HUNT: begin
                if (vs_edge)
                    state_nxt = ARM;
            end
            ARM: begin
                if (err)
                    state_nxt = HUNT;
                else if (vs_edge)
                    state_nxt = LOCKED;
            end
            LOCKED: begin
                if (err)
                    state_nxt = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Output decode
    always_comb begin
        locked      = 1'b0;
        pixel_valid = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        if (state == LOCKED) begin
            locked      = 1'b1;
            pixel_valid = active & ~err;
        end
        frame_start = pixel_valid && (hc == '0) && (vc == '0);
        frame_end   = pixel_valid && (hc == CW'(HMAX - 1)) && (vc == CW'(VMAX - 1));
    end

    // Edge-detect history, advanced only on pixel ticks
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            von_d <= 1'b0;
            vs_d  <= 1'b1;
        end else if (tick) begin
            von_d <= video_on;
            vs_d  <= vsync_n;
        end
    end

    // Position counters; a frame edge or a timing error restarts them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (vs_edge || err) begin
            hc <= '0;
            vc <= '0;
        end else if (line_end) begin
            hc <= '0;
            vc <= vc + CW'(1);
        end else if (active) begin
            hc <= hc + CW'(1);
        end
    end

    // Error pulse and saturating error count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_err  <= 1'b0;
            err_count <= '0;
        end else begin
            sync_err <= err;
            if (err && (err_count != {EW{1'b1}}))
                err_count <= err_count + EW'(1);
        end
    end

    assign x = hc;
    assign y = vc;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder with an 8x4 active frame and tick on every 2nd clk.
module tb_vga_sync_decoder;

    localparam int unsigned HMAX = 8;
    localparam int unsigned VMAX = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        video_on = 1'b0;
    logic        vsync_n = 1'b1;
    logic [10:0] x;
    logic [10:0] y;
    logic        pixel_valid;
    logic        frame_start;
    logic        frame_end;
    logic        locked;
    logic        sync_err;
    logic [7:0]  err_count;

    int          tests = 0;
    int          fails = 0;
    int          pv_cnt;
    int          fs_cnt;
    int          fe_cnt;
    int          se_cnt;
    int          gap_pv;
    logic [10:0] fs_x, fs_y, fe_x, fe_y;
    logic        last_pv;
    logic        last_se;

    vga_sync_decoder #(.HMAX(HMAX), .VMAX(VMAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .video_on    (video_on),
        .vsync_n     (vsync_n),
        .x           (x),
        .y           (y),
        .pixel_valid (pixel_valid),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .locked      (locked),
        .sync_err    (sync_err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_acc();
        pv_cnt = 0; fs_cnt = 0; fe_cnt = 0; se_cnt = 0;
        fs_x = '1; fs_y = '1; fe_x = '1; fe_y = '1;
    endtask

    // One tick cycle followed by one idle cycle; comb outputs sampled mid tick cycle.
    task automatic step(input logic von, input logic vsn);
        video_on = von;
        vsync_n  = vsn;
        tick     = 1'b1;
        @(negedge clk);
        last_pv = pixel_valid;
        if (pixel_valid) pv_cnt++;
        if (frame_start) begin fs_cnt++; fs_x = x; fs_y = y; end
        if (frame_end)   begin fe_cnt++; fe_x = x; fe_y = y; end
        @(posedge clk); #1;
        tick    = 1'b0;
        last_se = sync_err;
        if (sync_err) se_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic line(input int n);
        repeat (n) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
    endtask

    task automatic frame(input int n_lines);
        repeat (n_lines) line(HMAX);
    endtask

    task automatic vs();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    task automatic vs_short();
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
    endtask

    initial begin
        clear_acc();
        repeat (3) @(posedge clk);
        #1;
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_err_count", err_count, 0);
        check("rst_locked", locked, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_pixel_valid", pixel_valid, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_frame_end", frame_end, 0);
        reset = 1'b0;

        // Three clean frames
        vs();
        check("arm_not_locked", locked, 0);
        frame(4);
        check("arm_no_pixel_valid", pv_cnt, 0);
        check("locked_before_2nd_vs", locked, 0);
        vs();
        check("locked_after_2nd_vs", locked, 1);
        frame(4);
        vs();
        clear_acc();
        frame(4);
        check("f3_pixel_valid_cnt", pv_cnt, 32);
        check("f3_frame_start_cnt", fs_cnt, 1);
        check("f3_frame_end_cnt", fe_cnt, 1);
        check("f3_start_x", fs_x, 0);
        check("f3_start_y", fs_y, 0);
        check("f3_end_x", fe_x, 7);
        check("f3_end_y", fe_y, 3);
        check("clean_err_count", err_count, 0);
        vs();
        check("f3_still_locked", locked, 1);

        // Over-long line 2
        clear_acc();
        line(HMAX);
        line(HMAX);
        repeat (HMAX) step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("long_sync_err_pulse", last_se, 1);
        check("long_pixel_blocked", last_pv, 0);
        check("long_unlocked", locked, 0);
        check("long_sync_err_one_cycle", sync_err, 0);
        check("long_err_count", err_count, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        line(HMAX);
        vs();
        check("long_no_frame_end", fe_cnt, 0);
        check("long_single_pulse", se_cnt, 1);
        check("long_rearm_not_locked", locked, 0);
        frame(4);
        check("long_relock_pending", locked, 0);
        vs();
        check("long_relocked", locked, 1);

        // Three-line frame
        clear_acc();
        frame(3);
        vs();
        check("short_pulse", se_cnt, 1);
        check("short_err_count", err_count, 2);
        check("short_unlocked", locked, 0);
        frame(4);
        vs();
        check("short_armed_not_locked", locked, 0);
        frame(4);
        vs();
        check("short_relocked", locked, 1);

        // Line end and frame edge on the same tick
        clear_acc();
        frame(3);
        repeat (HMAX) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check("coinc_no_err", last_se, 0);
        check("coinc_locked", locked, 1);
        check("coinc_counters_cleared", {21'd0, y, x}, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        frame(4);
        check("coinc_pixel_valid_cnt", pv_cnt, 64);
        check("coinc_frame_start_cnt", fs_cnt, 2);
        check("coinc_frame_end_cnt", fe_cnt, 2);
        check("coinc_no_sync_err", se_cnt, 0);
        vs();
        check("coinc_locked_after", locked, 1);

        // 50-clock tick gap mid-line with misleading inputs
        clear_acc();
        line(HMAX);
        repeat (3) step(1'b1, 1'b1);
        video_on = 1'b1;
        vsync_n  = 1'b0;
        gap_pv   = 0;
        repeat (50) begin
            @(negedge clk);
            if (pixel_valid) gap_pv++;
            @(posedge clk); #1;
        end
        check("gap_pixel_valid", gap_pv, 0);
        check("gap_x", x, 3);
        check("gap_y", y, 1);
        check("gap_locked", locked, 1);
        repeat (HMAX - 3) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        line(HMAX);
        line(HMAX);
        check("gap_frame_pixels", pv_cnt, 32);
        check("gap_frame_end", fe_cnt, 1);
        check("gap_no_sync_err", se_cnt, 0);
        vs();
        check("gap_locked_after", locked, 1);

        // Asynchronous reset mid-line while locked
        line(HMAX);
        repeat (4) step(1'b1, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        check("arst_x", x, 0);
        check("arst_y", y, 0);
        check("arst_locked", locked, 0);
        check("arst_err_count", err_count, 0);
        check("arst_sync_err", sync_err, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_acc();
        line(HMAX + 1);
        line(HMAX);
        vs();
        check("hunt_no_sync_err", se_cnt, 0);
        check("hunt_err_count", err_count, 0);
        check("hunt_armed_not_locked", locked, 0);
        frame(4);
        vs();
        check("hunt_relocked", locked, 1);

        // 300 errors from back-to-back frame edges
        for (int i = 0; i < 508; i++) vs_short();
        check("sat_err_count_254", err_count, 254);
        for (int i = 0; i < 92; i++) vs_short();
        check("sat_err_count_255", err_count, 255);
        check("sat_not_locked", locked, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
